framebuffer_scanout: RTL
========================

# framebuffer_scanout

Read-side counterpart of the video generator: scans the framebuffer in raster order and emits one RGB565 pixel per handshake to a downstream display driver. It sits between the framebuffer read port and the panel interface. It hides the one-cycle framebuffer read latency behind a 2-entry skid FIFO, so full throughput holds under arbitrary backpressure. Each emitted pixel carries its coordinates and line/frame markers.

## Interface
- DISPLAY_WIDTH, 100, pixels per line (≥2)
- DISPLAY_HEIGHT, 100, lines per frame (≥1)
- FRAMEBUFFER_DATA_BITS, 16, pixel width (RGB565)
- FRAMEBUFFER_SIZE, DISPLAY_WIDTH*DISPLAY_HEIGHT, pixel count
- FRAMEBUFFER_ADDR_BITS, $clog2(FRAMEBUFFER_SIZE), address width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to scan one frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until frame_done
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  FRAMEBUFFER_ADDR_BITS  read address, linear y*DISPLAY_WIDTH+x
- fb_rd_data  in  FRAMEBUFFER_DATA_BITS  read data, valid the cycle after the edge that sampled fb_rd_en
- pixel_valid  out  1  pixel_data and markers valid
- pixel_ready  in  1  downstream accepts; transfer = valid & ready at posedge
- pixel_data  out  FRAMEBUFFER_DATA_BITS  pixel value
- pixel_x  out  $clog2(DISPLAY_WIDTH)  column of current pixel
- pixel_y  out  $clog2(DISPLAY_HEIGHT)  row of current pixel
- pixel_sof  out  1  current pixel is (0,0)
- pixel_eol  out  1  current pixel has x = DISPLAY_WIDTH-1
- pixel_eof  out  1  current pixel is the last in the frame
- frame_done  out  1  one-cycle pulse after the final pixel transfer

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: on start=1, clear the read address and output coordinate counters, then go to RUN. busy=0.
- RUN: issue a read when occupancy + inflight − (transfer this cycle ? 1 : 0) < 2. inflight is a 1-bit flag set by the issue edge; the returned word is pushed into the FIFO at the next edge. The read address increments per issue. After issuing address FRAMEBUFFER_SIZE-1, go to DRAIN.
- DRAIN: no reads. Go to IDLE on the transfer of the pixel at address FRAMEBUFFER_SIZE-1. Pulse frame_done the following cycle.
- FIFO: 2 entries. pixel_valid = FIFO non-empty. Head drives pixel_data. Push and pop may occur in the same cycle. Overflow is impossible by credit rule.
- Coordinates come from an output-side 2D counter that advances per transfer: x wraps at DISPLAY_WIDTH-1 with y++, and y wraps to 0 at frame end. Markers are combinational from that counter.
- AXI-stream rule: while valid & !ready, pixel_data, pixel_x/y and markers hold stable. valid never drops without a transfer.
- start while busy: ignored, with no effect on the current frame.
- Reset: asynchronous, so all state clears immediately. Outputs go to 0: busy, fb_rd_en, fb_rd_addr, pixel_valid, pixel_data, pixel_x, pixel_y, markers, frame_done. FIFO empties, inflight clears, FSM returns to IDLE. A read returning after reset is discarded.

## Timing
- start sampled at edge N: busy=1 and fb_rd_en=1 with addr 0 after N. Data is captured at N+2. pixel_valid=1 after N+2, a latency of 2 cycles.
- With pixel_ready held 1: one transfer per cycle, no bubbles, and frame transfers take FRAMEBUFFER_SIZE consecutive cycles.
- Final transfer at edge M: frame_done=1 and busy=0 during cycle M..M+1. A new start can be sampled at edge M+1.
- After pixel_ready drops: at most 2 further reads complete. Streaming resumes the cycle ready rises, with no bubble.

## Test plan
- Reset: assert rst=0 mid-cycle. All outputs read 0 asynchronously, and busy stays 0 after release without start.
- Full frame: W=4, H=3, fb[i]=i, ready=1, start pulse. Data 0..11 on 12 consecutive cycles, starting 2 cycles after start. sof on data 0, eol on 3/7/11, eof on 11, frame_done one cycle after the transfer of 11.
- Backpressure: same setup, ready=0 for 5 cycles while data 5 is at the head, then random ready. Data 5 and its x=1,y=1 stay stable. The sequence is 0..11 with no loss or duplicate. Outstanding reads never exceed 2, and fb_rd_addr never exceeds 11.
- Start handling: start pulses at pixels 3 and 8 are ignored, giving exactly 12 transfers. A start at frame_done+1 begins a new frame from address 0.
- Mid-frame reset: rst=0 after the transfer of data 6, with a read in flight. Everything returns to 0 and the stale read is not emitted. The next start outputs 0..11 from (0,0).
- Minimal geometry: W=2, H=1. Data 0 has sof=1 and data 1 has eol=eof=1.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer reader emitting RGB565 pixels on valid/ready with coordinates and line/frame markers.
// Start to first pixel takes 2 cycles; a 2-entry skid FIFO hides the read latency so ready may drop on any cycle.
module framebuffer_scanout #(
  parameter int DISPLAY_WIDTH         = 100,
  parameter int DISPLAY_HEIGHT        = 100,
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter int X_BITS                = $clog2(DISPLAY_WIDTH),
  parameter int Y_BITS                = (DISPLAY_HEIGHT > 1) ? $clog2(DISPLAY_HEIGHT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             fb_rd_en,
  output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
  output logic                             pixel_valid,
  input  logic                             pixel_ready,
  output logic [FRAMEBUFFER_DATA_BITS-1:0] pixel_data,
  output logic [X_BITS-1:0]                pixel_x,
  output logic [Y_BITS-1:0]                pixel_y,
  output logic                             pixel_sof,
  output logic                             pixel_eol,
  output logic                             pixel_eof,
  output logic                             frame_done
);

  localparam logic [FRAMEBUFFER_ADDR_BITS-1:0] LAST_ADDR = FRAMEBUFFER_ADDR_BITS'(FRAMEBUFFER_SIZE - 1);
  localparam logic [X_BITS-1:0]                X_LAST    = X_BITS'(DISPLAY_WIDTH - 1);
  localparam logic [Y_BITS-1:0]                Y_LAST    = Y_BITS'(DISPLAY_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [FRAMEBUFFER_ADDR_BITS-1:0]   rd_addr_q;
  logic                               inflight_q;
  logic [FRAMEBUFFER_DATA_BITS-1:0]   mem_q [2];
  logic                               wr_ptr_q, rd_ptr_q;
  logic [1:0]                         count_q;
  logic [X_BITS-1:0]                  x_q;
  logic [Y_BITS-1:0]                  y_q;
  logic                               frame_done_q;
  logic                               accept, issue, xfer, last_pix;

  assign pixel_valid = (count_q != 2'd0);
  assign xfer        = pixel_valid & pixel_ready;
  assign last_pix    = (x_q == X_LAST) && (y_q == Y_LAST);

  // A slot freed by this cycle's transfer can be reused immediately, which keeps ready=1 bubble-free.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        issue = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, xfer});
        if (issue && (rd_addr_q == LAST_ADDR)) state_d = DRAIN;
      end
      DRAIN: begin
        if (xfer && last_pix) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      inflight_q   <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) rd_addr_q <= '0;
      else if (issue && (rd_addr_q != LAST_ADDR)) rd_addr_q <= rd_addr_q + FRAMEBUFFER_ADDR_BITS'(1);
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= fb_rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, xfer};
      if (accept) begin
        x_q <= '0;
        y_q <= '0;
      end else if (xfer) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_BITS'(1);
        end else begin
          x_q <= x_q + X_BITS'(1);
        end
      end
      frame_done_q <= (state_q == DRAIN) && xfer && last_pix;
    end
  end

  assign busy       = (state_q != IDLE);
  assign fb_rd_en   = issue;
  assign fb_rd_addr = rd_addr_q;
  assign pixel_data = pixel_valid ? mem_q[rd_ptr_q] : '0;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign pixel_sof  = pixel_valid && (x_q == '0) && (y_q == '0);
  assign pixel_eol  = pixel_valid && (x_q == X_LAST);
  assign pixel_eof  = pixel_valid && last_pix;
  assign frame_done = frame_done_q;

endmodule
